// File: rtl/bb_bus_arbiter_if.sv
// rtl/bb_bus_arbiter_if.sv - bus arbitration handshake bundle between masters, split slave and arbiter
//
// Signals:
//   breq        per-master bus request (level)
//   bgrant      per-master grant, one-hot or zero
//   split       per-master split hold, high while that master is parked
//   msel        index of the current owner, drives the datapath mux
//   bus_busy    high while any bgrant bit is high
//   slave_split slave asks to split the current read
//   split_done  one-cycle pulse, split slave has data ready
// Modports:
//   master  arbiter view (drives grants, split holds and mux select)
//   slave   requester / slave view (drives requests and split signalling)
interface bb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int MSEL_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
    logic [NUM_MASTERS-1:0] breq;
    logic [NUM_MASTERS-1:0] bgrant;
    logic [NUM_MASTERS-1:0] split;
    logic [MSEL_W-1:0]      msel;
    logic                   bus_busy;
    logic                   slave_split;
    logic                   split_done;

    modport master (
        input  breq, slave_split, split_done,
        output bgrant, split, msel, bus_busy
    );

    modport slave (
        output breq, slave_split, split_done,
        input  bgrant, split, msel, bus_busy
    );
endinterface

// File: rtl/bb_bus_arbiter.sv
// rtl/bb_bus_arbiter.sv - serial system bus arbiter with one outstanding split transaction
//
// Shares the bus among NUM_MASTERS masters via breq/bgrant, drives the mux
// select and parks a master whose read was split until the slave completes.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin winner selection instead of
// fixed priority (index 0 highest).
//
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   bb_bus_arbiter_if.master: breq/slave_split/split_done in,
//         bgrant/split/msel/bus_busy out (all outputs registered)
module bb_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MSEL_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    bb_bus_arbiter_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
    logic [NUM_MASTERS-1:0] split_q, split_d;
    logic [MSEL_W-1:0]      msel_q, msel_d;
    logic [MSEL_W-1:0]      split_owner_q, split_owner_d;
    logic                   split_pending_q, split_pending_d;
    logic                   resume_q, resume_d;
    logic                   bus_busy_q;

    logic [NUM_MASTERS-1:0] eligible;
    logic                   any_eligible;
    logic [MSEL_W-1:0]      winner;
    logic                   abandon;

`ifdef ARB_ROUND_ROBIN_EN
    logic [MSEL_W-1:0]      rr_ptr_q, rr_ptr_d;
`endif

    // The parked master keeps breq high while waiting; it must not win a
    // normal arbitration round, only the resume path may grant it.
    always_comb begin
        eligible = bus.breq;
        if (split_pending_q) begin
            eligible[split_owner_q] = 1'b0;
        end
        any_eligible = |eligible;
    end

    always_comb begin
        winner = '0;
`ifdef ARB_ROUND_ROBIN_EN
        // Walk from furthest to nearest after rr_ptr so the nearest eligible
        // index is written last; k == NUM_MASTERS is rr_ptr itself (lowest).
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (eligible[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
                winner = MSEL_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
            end
        end
`else
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = MSEL_W'(i);
            end
        end
`endif
    end

    // Parked master gave up waiting: release the split bookkeeping.
    assign abandon = split_pending_q && !bus.breq[split_owner_q];

    always_comb begin
        state_d         = state_q;
        bgrant_d        = bgrant_q;
        split_d         = split_q;
        msel_d          = msel_q;
        split_owner_d   = split_owner_q;
        split_pending_d = split_pending_q;
        resume_d        = resume_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_d        = rr_ptr_q;
`endif

        // Completion is only meaningful once the split is registered; it is
        // remembered in resume until the bus goes idle.
        if (split_pending_q && bus.split_done) begin
            resume_d = 1'b1;
        end

        if (abandon) begin
            split_pending_d = 1'b0;
            resume_d        = 1'b0;
            split_d         = '0;
        end

        case (state_q)
            IDLE: begin
                if (resume_q && !abandon) begin
                    bgrant_d                = '0;
                    bgrant_d[split_owner_q] = 1'b1;
                    split_d                 = '0;
                    msel_d                  = split_owner_q;
                    split_pending_d         = 1'b0;
                    resume_d                = 1'b0;
                    state_d                 = BUSY;
                end else if (any_eligible) begin
                    bgrant_d         = '0;
                    bgrant_d[winner] = 1'b1;
                    msel_d           = winner;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_d         = winner;
`endif
                    state_d          = BUSY;
                end
            end
            BUSY: begin
                // Split wins over a simultaneous request drop; a second split
                // while one is outstanding is ignored.
                if (bus.slave_split && !split_pending_q) begin
                    split_owner_d   = msel_q;
                    split_pending_d = 1'b1;
                    bgrant_d        = '0;
                    split_d[msel_q] = 1'b1;
                    state_d         = IDLE;
                end else if (!bus.breq[msel_q]) begin
                    bgrant_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            bgrant_q        <= '0;
            split_q         <= '0;
            msel_q          <= '0;
            split_owner_q   <= '0;
            split_pending_q <= 1'b0;
            resume_q        <= 1'b0;
            bus_busy_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            bgrant_q        <= bgrant_d;
            split_q         <= split_d;
            msel_q          <= msel_d;
            split_owner_q   <= split_owner_d;
            split_pending_q <= split_pending_d;
            resume_q        <= resume_d;
            bus_busy_q      <= |bgrant_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign bus.bgrant   = bgrant_q;
    assign bus.split    = split_q;
    assign bus.msel     = msel_q;
    assign bus.bus_busy = bus_busy_q;

endmodule
